bp_update_ctrl: RTL and testbench

Sequences all writes into the two-level branch predictor tables (BHT history registers and PHT 2-bit counters) through one shared write port. After reset, and on a predictor flush request, it sweeps the tables to their initial values. It buffers branch outcomes resolved in MEM in a small FIFO and drains one per cycle into the tables. It also detects mispredictions in MEM and produces the flush/redirect for the front end.

---
 rtl/bp_update_ctrl.sv | 135 +++++++++++++
 tb/tb_bp_update_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bp_update_ctrl.sv
// Branch predictor table write sequencer: init sweep, outcome update FIFO,
// and MEM-stage misprediction detect/redirect.
module bp_update_ctrl #(
  parameter int BHT_DEPTH  = 10,
  parameter int PHT_DEPTH  = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_branchM,
  input  logic                 i_actual_takeM,
  input  logic                 i_pred_takeM,
  input  logic [31:0]          i_pcM,
  input  logic [31:0]          i_branch_targetM,
  input  logic [31:0]          i_pc_plus8M,
  input  logic                 i_flush_req,
  input  logic                 i_tbl_ready,
  output logic                 o_tbl_we,
  output logic                 o_tbl_clr,
  output logic [BHT_DEPTH-1:0] o_tbl_idx,
  output logic                 o_tbl_take,
  output logic                 o_pred_enable,
  output logic                 o_stall_req,
  output logic                 o_mispredictM,
  output logic [31:0]          o_redirect_pc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if (PHT_DEPTH > BHT_DEPTH) begin : g_bad_depth
    $error("PHT_DEPTH must not exceed BHT_DEPTH");
  end

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t               r_state, w_state_nxt;
  logic [BHT_DEPTH-1:0] r_sweep_cnt, w_sweep_nxt;
  logic                 r_pred_enable, w_pred_enable_nxt;
  logic [PW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]        r_count;
  logic [BHT_DEPTH:0]   r_fifo [FIFO_DEPTH];
  logic [BHT_DEPTH:0]   w_head;
  logic                 w_full, w_empty, w_push, w_pop, w_fifo_clr;
  logic                 w_unused_pc;

  assign w_unused_pc = ^{i_pcM[31:BHT_DEPTH+2], i_pcM[1:0]};
  assign w_full      = (r_count == CW'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_head      = r_fifo[r_rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_INIT;
      r_sweep_cnt   <= '0;
      r_pred_enable <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_sweep_cnt   <= w_sweep_nxt;
      r_pred_enable <= w_pred_enable_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_sweep_nxt       = r_sweep_cnt;
    w_pred_enable_nxt = r_pred_enable;
    w_push            = 1'b0;
    w_pop             = 1'b0;
    w_fifo_clr        = 1'b0;
    o_tbl_we          = 1'b0;
    o_tbl_clr         = 1'b0;
    o_tbl_idx         = '0;
    o_tbl_take        = 1'b0;
    case (r_state)
      ST_INIT: begin
        // rst gates the strobe so no init write leaks out while reset is held
        o_tbl_we          = i_tbl_ready & ~rst;
        o_tbl_clr         = 1'b1;
        o_tbl_idx         = r_sweep_cnt;
        w_pred_enable_nxt = 1'b0;
        if (i_flush_req) begin
          w_sweep_nxt = '0;
        end else if (i_tbl_ready) begin
          w_sweep_nxt = r_sweep_cnt + 1'b1;
          if (&r_sweep_cnt) begin
            w_state_nxt       = ST_RUN;
            w_pred_enable_nxt = 1'b1;
          end
        end
      end
      ST_RUN: begin
        o_tbl_we   = ~w_empty;
        o_tbl_idx  = w_head[BHT_DEPTH:1];
        o_tbl_take = w_head[0];
        if (i_flush_req) begin
          w_fifo_clr        = 1'b1;
          w_sweep_nxt       = '0;
          w_pred_enable_nxt = 1'b0;
          w_state_nxt       = ST_INIT;
        end else begin
          w_pop  = ~w_empty & i_tbl_ready;
          w_push = i_branchM & (~w_full | w_pop);
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_fifo_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {i_pcM[BHT_DEPTH+1:2], i_actual_takeM};
  end

  assign o_pred_enable = r_pred_enable;
  assign o_stall_req   = w_full & ~i_tbl_ready;
  assign o_mispredictM = i_branchM & (i_pred_takeM ^ i_actual_takeM);
  assign o_redirect_pc = i_actual_takeM ? i_branch_targetM : i_pc_plus8M;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed-vector bench for bp_update_ctrl with BHT_DEPTH = 4.
module tb_bp_update_ctrl;

  localparam int BD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          branchM, actual_takeM, pred_takeM, flush_req, tbl_ready;
  logic [31:0]   pcM, branch_targetM, pc_plus8M;
  logic          tbl_we, tbl_clr, tbl_take, pred_enable, stall_req, mispredictM;
  logic [BD-1:0] tbl_idx;
  logic [31:0]   redirect_pc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_update_ctrl #(.BHT_DEPTH(BD), .PHT_DEPTH(3), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .i_branchM(branchM), .i_actual_takeM(actual_takeM), .i_pred_takeM(pred_takeM),
    .i_pcM(pcM), .i_branch_targetM(branch_targetM), .i_pc_plus8M(pc_plus8M),
    .i_flush_req(flush_req), .i_tbl_ready(tbl_ready),
    .o_tbl_we(tbl_we), .o_tbl_clr(tbl_clr), .o_tbl_idx(tbl_idx), .o_tbl_take(tbl_take),
    .o_pred_enable(pred_enable), .o_stall_req(stall_req),
    .o_mispredictM(mispredictM), .o_redirect_pc(redirect_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic takes [5];

  initial begin
    takes[0] = 1'b1; takes[1] = 1'b0; takes[2] = 1'b1; takes[3] = 1'b1; takes[4] = 1'b0;
    rst = 1'b1; branchM = 1'b0; actual_takeM = 1'b0; pred_takeM = 1'b0;
    pcM = '0; branch_targetM = '0; pc_plus8M = '0; flush_req = 1'b0; tbl_ready = 1'b1;

    // reset state
    #3;
    chk("rst_we", tbl_we, 0);
    chk("rst_pred_en", pred_enable, 0);
    chk("rst_stall", stall_req, 0);
    cyc(); cyc();
    rst = 1'b0;

    // power-up sweep
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep_we", tbl_we, 1);
      chk("sweep_clr", tbl_clr, 1);
      chk("sweep_idx", tbl_idx, i);
      chk("sweep_pred_en", pred_enable, 0);
      cyc();
    end
    #1;
    chk("run_pred_en", pred_enable, 1);
    chk("run_idle_we", tbl_we, 0);

    // single update
    branchM = 1'b1; pcM = 32'h34; actual_takeM = 1'b1; pred_takeM = 1'b1;
    #1;
    chk("t2_no_mispred", mispredictM, 0);
    cyc();
    branchM = 1'b0;
    #1;
    chk("t2_we", tbl_we, 1);
    chk("t2_clr", tbl_clr, 0);
    chk("t2_idx", tbl_idx, 13);
    chk("t2_take", tbl_take, 1);
    cyc();
    #1;
    chk("t2_empty_we", tbl_we, 0);

    // fill to full with the write port blocked
    tbl_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      branchM = 1'b1; pcM = 32'((k + 1) << 2); actual_takeM = takes[k]; pred_takeM = takes[k];
      #1;
      chk("t3_nostall", stall_req, 0);
      cyc();
    end
    pcM = 32'(5 << 2); actual_takeM = takes[4]; pred_takeM = takes[4];
    #1;
    chk("t3_stall", stall_req, 1);
    chk("t3_head_idx", tbl_idx, 1);
    cyc();
    #1;
    chk("t3_stall_hold", stall_req, 1);
    tbl_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t3_drain_we", tbl_we, 1);
      chk("t3_drain_idx", tbl_idx, j + 1);
      chk("t3_drain_take", tbl_take, takes[j]);
      chk("t3_drain_stall", stall_req, 0);
      cyc();
      branchM = 1'b0;
    end
    #1;
    chk("t3_drained_we", tbl_we, 0);

    // misprediction detect and redirect
    branchM = 1'b1; pcM = 32'h0; pred_takeM = 1'b1; actual_takeM = 1'b0;
    pc_plus8M = 32'h1008; branch_targetM = 32'h2000;
    #1;
    chk("t4_mis_nt", mispredictM, 1);
    chk("t4_redir_nt", redirect_pc, 32'h1008);
    pred_takeM = 1'b0; actual_takeM = 1'b1;
    #1;
    chk("t4_mis_t", mispredictM, 1);
    chk("t4_redir_t", redirect_pc, 32'h2000);
    pred_takeM = 1'b1;
    #1;
    chk("t4_no_mis", mispredictM, 0);
    branchM = 1'b0; pred_takeM = 1'b0;
    #1;
    chk("t4_no_branch", mispredictM, 0);
    cyc();
    cyc();

    // flush with three queued entries
    tbl_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      branchM = 1'b1; pcM = 32'((k + 8) << 2); actual_takeM = 1'b1;
      cyc();
    end
    branchM = 1'b0; flush_req = 1'b1;
    cyc();
    flush_req = 1'b0; tbl_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      branchM = (i < 8);
      #1;
      chk("t5_we", tbl_we, 1);
      chk("t5_clr", tbl_clr, 1);
      chk("t5_idx", tbl_idx, i);
      chk("t5_pred_en", pred_enable, 0);
      chk("t5_stall", stall_req, 0);
      cyc();
    end
    branchM = 1'b0;
    #1;
    chk("t5_pred_en_done", pred_enable, 1);
    chk("t5_no_stale_we", tbl_we, 0);

    // reset mid-sweep, then throttled sweep
    flush_req = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 7; i++) cyc();
    #1;
    chk("t6_idx7", tbl_idx, 7);
    rst = 1'b1;
    #1;
    chk("t6_rst_we", tbl_we, 0);
    chk("t6_rst_pred_en", pred_enable, 0);
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 32; c++) begin
      tbl_ready = ((c % 2) == 0);
      #1;
      chk("t6_we", tbl_we, tbl_ready && c < 31);
      if (c % 2 == 0) begin
        chk("t6_idx", tbl_idx, c / 2);
        chk("t6_clr", tbl_clr, 1);
      end
      chk("t6_pred_en", pred_enable, c == 31);
      cyc();
    end
    #1;
    chk("t6_pred_en_done", pred_enable, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
